vram_stream_reader: RTL
=======================

# vram_stream_reader

Streams a contiguous run of words out of the dual-port video/work RAM onto a valid/ready stream. It sits directly downstream of the RAM's read port: it drives the address, absorbs the RAM's one-cycle registered read latency, and buffers into a small show-ahead FIFO so downstream backpressure never loses data. Typical consumers are the scanout, sprite or DMA-copy stages of the sim core.

## Interface

Parameters:
- `DW`, default 8: RAM and stream data width; matches the RAM's `width_a`.
- `AW`, default 10: RAM address width; matches the RAM's `widthad_a`.
- `DEPTH`, default 4: output FIFO entries; power of two, at least 4. A value of 4 is needed for one word per cycle sustained.

Ports:
- `clock` in 1: single clock for all logic. The RAM port this block drives is on the same clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `start` in 1: one-cycle command strobe. Sampled only in IDLE.
- `base_addr` in AW: first RAM address. Sampled with `start`.
- `length` in AW: word count. Sampled with `start`. Value 0 means 2**AW words.
- `abort` in 1: cancels the transfer. Has priority over everything except reset.
- `busy` out 1: high in RUN and DRAIN.
- `done` out 1: one-cycle pulse when the last word is accepted downstream.
- `ram_addr` out AW: registered read address to the RAM port.
- `ram_rd` out 1: registered; high in each cycle `ram_addr` is a real read. Write-enable to the RAM port is tied 0 externally.
- `ram_q` in DW: RAM read data. Holds mem[`ram_addr`] of the previous cycle.
- `out_data` out DW: FIFO head word. Show-ahead.
- `out_valid` out 1: FIFO is non-empty.
- `out_ready` in 1: downstream accept. A transfer occurs when `out_valid` and `out_ready` are both high.

## Operation

State machine:
- **IDLE**
  - `start` latches `base_addr` into the address counter and `length` (0 becomes 2**AW) into the AW+1-bit `remaining` counter.
  - Goes to RUN.
- **RUN**
  - Issues a read when `remaining` > 0 and `count + rd_d + ram_rd < DEPTH`.
    - `count` is the FIFO occupancy.
    - `rd_d` is `ram_rd` delayed one cycle; it marks data now present on `ram_q`.
    - Pops in the same cycle are not credited, so the check is conservative.
  - An issue sets `ram_rd`=1 and `ram_addr`=counter on the next edge, increments the counter and decrements `remaining`.
  - The address counter wraps from 2**AW-1 to 0.
  - Goes to DRAIN when the final read is issued (`remaining` becomes 0).
- **DRAIN**
  - No issues.
  - When `rd_d`=0, `ram_rd`=0, the FIFO holds exactly one word and that word transfers: pulse `done` on the next cycle and go to IDLE.
  - If no data is pending (`rd_d`=0, `ram_rd`=0) and the FIFO is already empty: pulse `done` and go to IDLE.

FIFO and read path:
- FIFO write enable is `rd_d`; write data is `ram_q`.
- A write and a pop may occur in the same cycle. `count` is then unchanged.
- Words leave in address order.

Command and abort handling:
- `start` while `busy` is ignored. Latched parameters are unaffected.
- `abort` in any state:
  - next edge: state IDLE, FIFO emptied, `ram_rd`=0, `rd_d`=0, `remaining`=0, no `done`.
  - RAM data already in flight is discarded.
  - `start` in the same cycle as `abort` is ignored.

## Timing

- Reset values (asserted asynchronously): state IDLE, `busy` 0, `done` 0, `ram_rd` 0, `ram_addr` 0, `out_valid` 0, `out_data` 0, FIFO count 0.
- Reset mid-transfer behaves exactly like abort, but takes effect immediately.
- First-word latency, for `start` sampled at edge E0:
  - E0: `busy`=1 and `ram_addr`=base with `ram_rd`=1 are both visible after this edge (cycle 1). The first issue is decided in the `start` cycle.
  - After E1: `ram_q` holds the data.
  - After E2: FIFO written and `out_valid`=1.
- Throughput: with `out_ready` held high, DEPTH ≥ 4 gives one word per cycle.
- `done` is asserted in the cycle after the last transfer. `busy` drops in that same cycle.

## Test plan

- **Basic run:** preload mem[i]=i, `start` with base=5, length=4, `out_ready`=1 → `out_data` 5,6,7,8 on 4 consecutive cycles, first `out_valid` 3 cycles after `start`; one `done` pulse; `busy` low afterwards.
- **Wrap and length 0:** AW=10, base=1022, length=3 → addresses 1022,1023,0. length=0 → exactly 1024 words, then `done`.
- **Backpressure:** length=16, `out_ready` random 30% → all 16 words in order, none lost or duplicated. FIFO count never exceeds DEPTH; no issue while `count+rd_d+ram_rd` ≥ DEPTH. With `out_ready`=0 and length=16, issuing stops once 4 words are resident or in flight, and `out_valid` stays high on word 0.
- **Abort:** length=10, assert `abort` after 3 transfers → next cycle `busy`=0, `out_valid`=0, no `done`. A new `start` with base=100 delivers mem[100] first.
- **Ignored start:** `start` pulse while `busy` with a different base → stream unchanged, single `done`.
- **Reset mid-stream:** deassert `reset_n` during RUN → outputs immediately at reset values. After release, a fresh `start` works normally.

Source files
------------

// File: rtl/vram_stream_reader.sv
// vram_stream_reader
//   Streams a contiguous run of RAM words onto a valid/ready stream. It
//   drives the RAM read port, absorbs the RAM's one-cycle registered read
//   latency and buffers words in a small show-ahead FIFO. Because reads are
//   only issued against free FIFO space, downstream backpressure never
//   loses data.
//
// Ports
//   clock, reset_n      : clock, asynchronous active-low reset
//   start               : command strobe, sampled only while idle
//   base_addr, length   : first address and word count (length 0 = 2**AW words)
//   abort               : cancel the transfer and flush everything
//   busy, done          : transfer in progress / one-cycle completion pulse
//   ram_addr, ram_rd    : registered RAM read address and read strobe
//   ram_q               : RAM read data (mem[ram_addr] of the previous cycle)
//   out_data, out_valid : FIFO head word (show-ahead) and non-empty flag
//   out_ready           : downstream accept
//   dbg_state           : current FSM state (0 idle, 1 run, 2 drain)
//
// Stream handshake: a word moves in every cycle where out_valid and
// out_ready are both high. out_valid never depends on out_ready, and
// out_data holds steady while out_valid is high and the word is not taken.

module vram_stream_reader #(
   parameter int DW    = 8,
   parameter int AW    = 10,
   parameter int DEPTH = 4
) (
   input  logic          clock,
   input  logic          reset_n,
   input  logic          start,
   input  logic [AW-1:0] base_addr,
   input  logic [AW-1:0] length,
   input  logic          abort,
   output logic          busy,
   output logic          done,
   output logic [AW-1:0] ram_addr,
   output logic          ram_rd,
   input  logic [DW-1:0] ram_q,
   output logic [DW-1:0] out_data,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [1:0]    dbg_state
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_DRAIN = 2'd2
   } state_t;

   state_t          state_q,     state_d;
   logic [AW-1:0]   addr_q,      addr_d;       // next address to read
   logic [AW-1:0]   ram_addr_q,  ram_addr_d;
   logic            ram_rd_q,    ram_rd_d;
   logic            rd_dly_q,    rd_dly_d;     // ram_q carries a requested word
   logic [AW:0]     remaining_q, remaining_d;  // reads still to issue
   logic            done_q,      done_d;
   logic [CW-1:0]   count_q,     count_d;
   logic [PW-1:0]   wr_ptr_q,    wr_ptr_d;
   logic [PW-1:0]   rd_ptr_q,    rd_ptr_d;
   logic [DW-1:0]   fifo_mem [DEPTH];

   logic            push;
   logic            pop;
   logic [CW+1:0]   pending;
   logic            can_issue;
   logic [AW:0]     len_full;

   assign push = rd_dly_q;
   assign pop  = out_valid && out_ready;

   // Words resident plus words still travelling through the RAM. Pops in
   // the current cycle are not credited, so this never overcommits.
   assign pending   = (CW+2)'(count_q) + (CW+2)'(rd_dly_q) + (CW+2)'(ram_rd_q);
   assign can_issue = (remaining_q != '0) && (pending < (CW+2)'(DEPTH));

   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      ram_addr_d  = ram_addr_q;
      ram_rd_d    = 1'b0;
      rd_dly_d    = ram_rd_q;
      remaining_d = remaining_q;
      done_d      = 1'b0;
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      count_d     = count_q;
      len_full    = (length == '0) ? {1'b1, {AW{1'b0}}} : {1'b0, length};

      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      if (push && !pop)      count_d = count_q + CW'(1);
      else if (!push && pop) count_d = count_q - CW'(1);

      case (state_q)
         S_IDLE: begin
            // The first read is issued straight from the start cycle so
            // the address reaches the RAM one edge after the command.
            if (start) begin
               ram_addr_d  = base_addr;
               ram_rd_d    = 1'b1;
               addr_d      = base_addr + AW'(1);
               remaining_d = len_full - (AW+1)'(1);
               state_d     = (len_full == (AW+1)'(1)) ? S_DRAIN : S_RUN;
            end
         end
         S_RUN: begin
            if (can_issue) begin
               ram_addr_d  = addr_q;
               ram_rd_d    = 1'b1;
               addr_d      = addr_q + AW'(1);
               remaining_d = remaining_q - (AW+1)'(1);
               if (remaining_q == (AW+1)'(1)) state_d = S_DRAIN;
            end
         end
         S_DRAIN: begin
            // Finish once nothing is left in the RAM pipe and the last
            // resident word leaves (or the FIFO is already empty).
            if (!rd_dly_q && !ram_rd_q) begin
               if (count_q == '0) begin
                  done_d  = 1'b1;
                  state_d = S_IDLE;
               end else if (count_q == CW'(1) && pop) begin
                  done_d  = 1'b1;
                  state_d = S_IDLE;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase

      if (abort) begin
         state_d     = S_IDLE;
         ram_rd_d    = 1'b0;
         rd_dly_d    = 1'b0;
         remaining_d = '0;
         done_d      = 1'b0;
         count_d     = '0;
         wr_ptr_d    = '0;
         rd_ptr_d    = '0;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= S_IDLE;
         addr_q      <= '0;
         ram_addr_q  <= '0;
         ram_rd_q    <= 1'b0;
         rd_dly_q    <= 1'b0;
         remaining_q <= '0;
         done_q      <= 1'b0;
         count_q     <= '0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         ram_addr_q  <= ram_addr_d;
         ram_rd_q    <= ram_rd_d;
         rd_dly_q    <= rd_dly_d;
         remaining_q <= remaining_d;
         done_q      <= done_d;
         count_q     <= count_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
      end
   end

   // Storage needs no reset: an entry is only visible once count covers it.
   always_ff @(posedge clock) begin
      if (push) fifo_mem[wr_ptr_q] <= ram_q;
   end

   assign busy      = (state_q != S_IDLE);
   assign done      = done_q;
   assign ram_addr  = ram_addr_q;
   assign ram_rd    = ram_rd_q;
   assign out_valid = (count_q != '0);
   assign out_data  = out_valid ? fifo_mem[rd_ptr_q] : '0;
   assign dbg_state = state_q;

endmodule
